// File: rtl/sr_button_conditioner_pkg.sv
// sr_button_conditioner_pkg: shared debounce state encoding and default timing
package sr_button_conditioner_pkg;
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
endpackage

// File: rtl/sr_button_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchroniser plus counting debounce FSM for one button
module debounce_channel
  import sr_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q;
  logic sync;
  db_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic last;
  assign sync = sync_q[1];
  assign last = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign stable = state == HIGH || state == WAIT_LOW;
  // synchroniser, state and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      state  <= LOW;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      state  <= state_n;
      cnt    <= cnt_n;
    end
  end
  // a new level is accepted only after it holds for DEBOUNCE_CYCLES samples; any bounce restarts the count
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise    = 1'b0;
    fall    = 1'b0;
    case (state)
      LOW: if (sync) begin
        state_n = WAIT_HIGH;
        cnt_n   = CNT_W'(1);
      end
      WAIT_HIGH: if (!sync) begin
        state_n = LOW;
        cnt_n   = '0;
      end else if (last) begin
        state_n = HIGH;
        cnt_n   = '0;
        rise    = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      HIGH: if (!sync) begin
        state_n = WAIT_LOW;
        cnt_n   = CNT_W'(1);
      end
      WAIT_LOW: if (sync) begin
        state_n = HIGH;
        cnt_n   = '0;
      end else if (last) begin
        state_n = LOW;
        cnt_n   = '0;
        fall    = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      default: begin
        state_n = LOW;
        cnt_n   = '0;
      end
    endcase
  end
endmodule

// File: rtl/sr_button_conditioner.sv
// sr_button_conditioner: debounced set/reset buttons to single-cycle SR latch pulses, never S=R=1
module sr_button_conditioner
  import sr_button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic set_stable,
  output logic reset_stable,
  output logic conflict
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic rise_s, fall_s, rise_r, fall_r;
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_set (
    .clk(clk), .reset(reset), .raw(btn_set),
    .stable(set_stable), .rise(rise_s), .fall(fall_s)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset (
    .clk(clk), .reset(reset), .raw(btn_reset),
    .stable(reset_stable), .rise(rise_r), .fall(fall_r)
  );
  // simultaneous presses are reported as a conflict and suppressed so the latch never sees S=R=1
  always_ff @(posedge clk) begin
    if (reset) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      S        <= rise_s & ~rise_r;
      R        <= rise_r & ~rise_s;
      conflict <= rise_s & rise_r;
    end
  end
  a_no_sr: assert property (@(posedge clk) disable iff (reset) !(S && R));
  a_edge_excl: assert property (@(posedge clk) disable iff (reset) !((rise_s && fall_s) || (rise_r && fall_r)));
endmodule

// File: tb/tb_sr_button_conditioner.sv
// tb_sr_button_conditioner: directed and random bounce stimulus against a run-length reference model
module tb_sr_button_conditioner;
  localparam int DC = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  logic S, R, set_stable, reset_stable, conflict;
  int total = 0;
  int bad = 0;
  int n_s = 0;
  int n_r = 0;
  int n_c = 0;
  bit q_s[$];
  bit q_r[$];
  bit st_s = 0;
  bit st_r = 0;
  int run_s = 0;
  int run_r = 0;
  bit e_s = 0;
  bit e_r = 0;
  bit e_c = 0;

  always #5 clk = ~clk;

  sr_button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn_set(btn_set), .btn_reset(btn_reset),
    .S(S), .R(R), .set_stable(set_stable), .reset_stable(reset_stable),
    .conflict(conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // accepted level flips once DC consecutive samples disagree with it
  function automatic void chan(input bit seen, inout bit st, inout int run, output bit rise);
    rise = 0;
    if (seen != st) begin
      run++;
      if (run == DC) begin
        st = seen;
        run = 0;
        rise = seen;
      end
    end else run = 0;
  endfunction

  task automatic step(input bit bs, input bit br, input bit rs);
    bit rise_s, rise_r;
    btn_set = bs;
    btn_reset = br;
    reset = rs;
    @(posedge clk);
    if (rs) begin
      q_s = {1'b0, 1'b0};
      q_r = {1'b0, 1'b0};
      st_s = 0; st_r = 0; run_s = 0; run_r = 0;
      e_s = 0; e_r = 0; e_c = 0;
    end else begin
      chan(q_s.pop_front(), st_s, run_s, rise_s);
      chan(q_r.pop_front(), st_r, run_r, rise_r);
      q_s.push_back(bs);
      q_r.push_back(br);
      e_s = rise_s & ~rise_r;
      e_r = rise_r & ~rise_s;
      e_c = rise_s & rise_r;
    end
    #1;
    check("S", S, e_s);
    check("R", R, e_r);
    check("conflict", conflict, e_c);
    check("set_stable", set_stable, st_s);
    check("reset_stable", reset_stable, st_r);
    n_s += int'(S);
    n_r += int'(R);
    n_c += int'(conflict);
  endtask

  task automatic hold(input bit bs, input bit br, input int n);
    for (int i = 0; i < n; i++) step(bs, br, 1'b0);
  endtask

  initial begin
    bit pat[9];
    pat = '{1, 1, 0, 1, 0, 0, 1, 1, 0};
    q_s = {1'b0, 1'b0};
    q_r = {1'b0, 1'b0};
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 1);
    hold(1, 1, 10);
    hold(0, 0, 10);
    n_s = 0; n_r = 0; n_c = 0;
    hold(1, 0, 20);
    check("scn2_s_pulses", n_s, 1);
    check("scn2_r_pulses", n_r, 0);
    check("scn2_conflicts", n_c, 0);
    n_s = 0; n_r = 0;
    hold(0, 0, 10);
    check("scn4_release_pulses", n_s + n_r, 0);
    hold(1, 0, 10);
    check("scn4_second_press", n_s, 1);
    hold(0, 0, 10);
    n_s = 0;
    foreach (pat[i]) step(pat[i], 0, 0);
    check("scn3_bounce_no_s", n_s, 0);
    hold(1, 0, 12);
    check("scn3_one_s", n_s, 1);
    hold(0, 0, 10);
    n_s = 0; n_r = 0; n_c = 0;
    hold(1, 1, 12);
    check("scn5_conflict", n_c, 1);
    check("scn5_no_sr", n_s + n_r, 0);
    hold(0, 0, 10);
    n_r = 0;
    hold(0, 1, 4);
    step(0, 1, 1);
    check("scn6_no_r_before_reset", n_r, 0);
    hold(0, 1, 12);
    check("scn6_one_r", n_r, 1);
    hold(1, 1, 10);
    n_s = 0;
    hold(1, 0, 12);
    check("held_reset_then_release_no_s", n_s, 0);
    hold(0, 0, 10);
    repeat (150) begin
      bit ts, tr;
      ts = 1'($urandom_range(0, 1));
      tr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 4)) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 30) == 0) step(ts, tr, 1'b1);
      hold(ts, tr, $urandom_range(0, 10));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
